// File: rtl/magia_tile_pkg.sv
// Shared types and constants for the fractal barrier-synchronisation tree.
package magia_tile_pkg;

  localparam int FSYNC_LVL_W    = 3;
  localparam int FSYNC_NODE_LVL = 1;

  typedef enum logic [1:0] {
    NODE_IDLE,
    NODE_FWD,
    NODE_WAIT_UP,
    NODE_WAKE
  } fsync_node_state_e;

  function automatic logic fsync_lvl_illegal(input int lvl, input int node_lvl, input int max_lvl);
    return (lvl == 0) || (lvl < node_lvl) || (lvl > max_lvl);
  endfunction

endpackage

// File: rtl/fractal_if.sv
// Barrier handshake between a tree node and one neighbour (child or parent).
interface fractal_if #(
  parameter int LVL_W = magia_tile_pkg::FSYNC_LVL_W
);
  logic             sync;
  logic [LVL_W-1:0] lvl;
  logic             ack;
  logic             wake;
  logic             error;

  modport mst_port (output sync, lvl, ack, input wake, error);
  modport slv_port (input sync, lvl, ack, output wake, error);
endinterface

// File: rtl/fractal_sync_node_ch.sv
// Per-child request latch, level legality check and wake/ack tracker.
module fractal_sync_node_ch
  import magia_tile_pkg::*;
#(
  parameter int LVL_W    = FSYNC_LVL_W,
  parameter int NODE_LVL = FSYNC_NODE_LVL,
  parameter int MAX_LVL  = 2**LVL_W-1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             sync_i,
  input  logic [LVL_W-1:0] lvl_i,
  input  logic             ack_i,
  input  logic             wake_set_i,
  input  logic             wake_err_i,
  output logic             pend_o,
  output logic [LVL_W-1:0] lvl_o,
  output logic             done_o,
  output logic             wake_o,
  output logic             err_o
);

  logic             pend_q, pend_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             wake_q, wake_d;
  logic             err_q, err_d;
  logic             busy, illegal, accept;

  assign busy    = pend_q | wake_q;
  assign illegal = fsync_lvl_illegal(32'(lvl_i), NODE_LVL, MAX_LVL);
  assign accept  = sync_i & ~busy;

  // Effective view includes a legal request arriving this cycle, so the node
  // can pair it with the other child without waiting for the latch.
  assign pend_o = pend_q | (accept & ~illegal);
  assign lvl_o  = pend_q ? lvl_q : lvl_i;
  assign done_o = ~wake_q | ack_i;
  assign wake_o = wake_q;
  assign err_o  = err_q;

  always_comb begin
    pend_d = pend_q;
    lvl_d  = lvl_q;
    wake_d = wake_q;
    err_d  = err_q;
    if (wake_q && ack_i) begin
      wake_d = 1'b0;
      err_d  = 1'b0;
    end
    if (accept) begin
      if (illegal) begin
        wake_d = 1'b1;
        err_d  = 1'b1;
      end else begin
        pend_d = 1'b1;
        lvl_d  = lvl_i;
      end
    end
    if (wake_set_i) begin
      pend_d = 1'b0;
      wake_d = 1'b1;
      err_d  = wake_err_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      lvl_q  <= '0;
      wake_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (clear_i) begin
      pend_q <= 1'b0;
      lvl_q  <= '0;
      wake_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      lvl_q  <= lvl_d;
      wake_q <= wake_d;
      err_q  <= err_d;
    end
  end

  // A child must not re-sync while its previous request is still open.
  a_no_sync_while_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) !(sync_i && busy));

endmodule

// File: rtl/fractal_sync_node.sv
// Two-child barrier node: pairs child requests, resolves locally or forwards up.
module fractal_sync_node
  import magia_tile_pkg::*;
#(
  parameter int LVL_W    = magia_tile_pkg::FSYNC_LVL_W,
  parameter int NODE_LVL = magia_tile_pkg::FSYNC_NODE_LVL,
  parameter int MAX_LVL  = 2**LVL_W-1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  fractal_if.slv_port   ch0_if_i,
  fractal_if.slv_port   ch1_if_i,
  fractal_if.mst_port   up_if_o
);

  localparam logic [LVL_W-1:0] NODE_LVL_L = LVL_W'(NODE_LVL);

  fsync_node_state_e state_q, state_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              from_up_q, from_up_d;
  logic              up_ack_q, up_ack_d;
  logic              wake_set, wake_err;

  logic             pend0, pend1, done0, done1;
  logic [LVL_W-1:0] lvl0, lvl1;
  logic             wake0, wake1, err0, err1;

  fractal_sync_node_ch #(.LVL_W(LVL_W), .NODE_LVL(NODE_LVL), .MAX_LVL(MAX_LVL)) u_ch0 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .sync_i     (ch0_if_i.sync),
    .lvl_i      (ch0_if_i.lvl),
    .ack_i      (ch0_if_i.ack),
    .wake_set_i (wake_set),
    .wake_err_i (wake_err),
    .pend_o     (pend0),
    .lvl_o      (lvl0),
    .done_o     (done0),
    .wake_o     (wake0),
    .err_o      (err0)
  );

  fractal_sync_node_ch #(.LVL_W(LVL_W), .NODE_LVL(NODE_LVL), .MAX_LVL(MAX_LVL)) u_ch1 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .sync_i     (ch1_if_i.sync),
    .lvl_i      (ch1_if_i.lvl),
    .ack_i      (ch1_if_i.ack),
    .wake_set_i (wake_set),
    .wake_err_i (wake_err),
    .pend_o     (pend1),
    .lvl_o      (lvl1),
    .done_o     (done1),
    .wake_o     (wake1),
    .err_o      (err1)
  );

  assign ch0_if_i.wake  = wake0;
  assign ch0_if_i.error = err0;
  assign ch1_if_i.wake  = wake1;
  assign ch1_if_i.error = err1;

  assign up_if_o.sync = (state_q == NODE_FWD);
  assign up_if_o.lvl  = (state_q == NODE_FWD) ? lvl_q : '0;
  assign up_if_o.ack  = up_ack_q;

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    from_up_d = from_up_q;
    up_ack_d  = 1'b0;
    wake_set  = 1'b0;
    wake_err  = 1'b0;
    case (state_q)
      NODE_IDLE: begin
        if (pend0 && pend1) begin
          if (lvl0 != lvl1) begin
            wake_set  = 1'b1;
            wake_err  = 1'b1;
            from_up_d = 1'b0;
            state_d   = NODE_WAKE;
          end else if (lvl0 == NODE_LVL_L) begin
            wake_set  = 1'b1;
            from_up_d = 1'b0;
            state_d   = NODE_WAKE;
          end else begin
            lvl_d   = lvl0;
            state_d = NODE_FWD;
          end
        end
      end
      NODE_FWD: state_d = NODE_WAIT_UP;
      NODE_WAIT_UP: begin
        if (up_if_o.wake) begin
          wake_set  = 1'b1;
          wake_err  = up_if_o.error;
          from_up_d = 1'b1;
          state_d   = NODE_WAKE;
        end
      end
      NODE_WAKE: begin
        // The parent is only acked for barriers it actually released.
        if (done0 && done1) begin
          up_ack_d = from_up_q;
          state_d  = NODE_IDLE;
        end
      end
      default: state_d = NODE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= NODE_IDLE;
      lvl_q     <= '0;
      from_up_q <= 1'b0;
      up_ack_q  <= 1'b0;
    end else if (clear_i) begin
      state_q   <= NODE_IDLE;
      lvl_q     <= '0;
      from_up_q <= 1'b0;
      up_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      from_up_q <= from_up_d;
      up_ack_q  <= up_ack_d;
    end
  end

endmodule
